// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte streams share one UART transmitter.
// A requester owns the transmitter for a whole packet (until its last byte is
// accepted) or until it stalls for HOLD_TIMEOUT consecutive cycles mid-packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 timeout_evt
);

  localparam int                PTR_W     = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [15:0]       TIMEOUT_L = 16'(HOLD_TIMEOUT);
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PTR_W-1:0]   owner_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [15:0]        cnt_q;
  logic               timeout_evt_q;

  logic               arb_found_d;
  logic [PTR_W-1:0]   arb_idx_d;
  logic [NUM_REQ-1:0] arb_onehot_d;
  int                 best_off;
  int                 cand_off;

  logic               in_lock;
  logic               own_valid;
  logic               own_last;
  logic               xfer;
  logic [15:0]        cnt_d;
  logic               timeout_hit;
  logic [PTR_W-1:0]   ptr_d;

  // Pick the valid requester closest to ptr_q in rotating order.
  always_comb begin
    arb_found_d = 1'b0;
    arb_idx_d   = '0;
    best_off    = NUM_REQ;
    cand_off    = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand_off = (j + NUM_REQ - int'(ptr_q)) % NUM_REQ;
      if (req_valid[j] && (cand_off < best_off)) begin
        best_off    = cand_off;
        arb_found_d = 1'b1;
        arb_idx_d   = PTR_W'(j);
      end
    end
  end

  assign arb_onehot_d = NUM_REQ'(1) << arb_idx_d;

  // Owner routing: purely combinational so backpressure passes straight through.
  assign in_lock   = (state_q == S_LOCK);
  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign tx_valid  = in_lock & own_valid;
  assign tx_data   = in_lock ? req_data[{owner_q, 3'b000} +: 8] : 8'h00;
  assign req_ready = grant_q & {NUM_REQ{tx_ready}};
  assign xfer      = tx_valid & tx_ready;

  // Idle counter saturates so that a disabled timeout can never wrap into a false hit.
  assign cnt_d       = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign timeout_hit = (HOLD_TIMEOUT != 0) && in_lock && !own_valid && (cnt_d == TIMEOUT_L);
  assign ptr_d       = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  assign grant       = grant_q;
  assign timeout_evt = timeout_evt_q;

  // Ownership FSM: grant on a request, release on last-beat transfer or stall timeout.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      ptr_q         <= '0;
      cnt_q         <= '0;
      timeout_evt_q <= 1'b0;
    end else begin
      timeout_evt_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (arb_found_d) begin
          state_q <= S_LOCK;
          owner_q <= arb_idx_d;
          grant_q <= arb_onehot_d;
          cnt_q   <= '0;
        end
      end else begin
        if (xfer && own_last) begin
          // Packet complete; next arbitration happens from IDLE, never on this edge.
          state_q <= S_IDLE;
          grant_q <= '0;
          ptr_q   <= ptr_d;
          cnt_q   <= '0;
        end else if (timeout_hit) begin
          state_q       <= S_IDLE;
          grant_q       <= '0;
          ptr_q         <= ptr_d;
          cnt_q         <= '0;
          timeout_evt_q <= 1'b1;
        end else if (own_valid) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected transfers go into a scoreboard
// queue, a negedge monitor pops and compares every accepted byte.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int HOLD_TIMEOUT = 4;

  logic                 clk_sys = 1'b0;
  logic                 rst_sys_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 timeout_evt;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;
  logic [1:0] exp_g [7] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .HOLD_TIMEOUT (HOLD_TIMEOUT)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_sys_n   (rst_sys_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant       (grant),
    .timeout_evt (timeout_evt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic to_edge();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic to_mid();
    @(negedge clk_sys);
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d1, input logic [7:0] d0,
                       input logic [1:0] l);
    req_valid = v;
    req_data  = {d1, d0};
    req_last  = l;
  endtask

  // Scoreboard monitor: every accepted byte must match the next expected {grant, data}.
  always @(negedge clk_sys) begin
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tx_unexpected: got grant=%b data=0x%02h, required no transfer (t=%0t)",
                 grant, tx_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("tx_beat", 32'({grant, tx_data}), 32'(mon_exp));
        chk("tx_ready_route", 32'(req_ready), 32'(mon_exp[9:8]));
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk_sys);
    $display("FAIL watchdog: still running after 5000 cycles, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst_sys_n = 1'b0;
    tx_ready  = 1'b1;
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    repeat (2) to_mid();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_timeout_evt", 32'(timeout_evt), 32'd0);
    #1 rst_sys_n = 1'b1;
    repeat (2) to_mid();
    chk("idle_no_request", 32'(grant), 32'd0);

    // Single 3-byte packet from requester 0
    to_edge();
    drive(2'b01, 8'h00, 8'h41, 2'b00);
    exp_q.push_back({2'b01, 8'h41});
    exp_q.push_back({2'b01, 8'h42});
    exp_q.push_back({2'b01, 8'h43});
    to_mid();
    chk("single_grant_latency", 32'(grant), 32'd0);
    @(posedge clk_sys);
    to_mid();
    chk("single_grant", 32'(grant), 32'b01);
    to_edge();
    drive(2'b01, 8'h00, 8'h42, 2'b00);
    to_edge();
    drive(2'b01, 8'h00, 8'h43, 2'b01);
    to_edge();
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    to_mid();
    chk("single_release", 32'(grant), 32'd0);

    // Contention with 1-byte packets; pointer now at 1 so requester 1 goes first
    to_edge();
    drive(2'b11, 8'hB1, 8'hA0, 2'b11);
    exp_q.push_back({2'b10, 8'hB1});
    exp_q.push_back({2'b01, 8'hA0});
    exp_q.push_back({2'b10, 8'hB1});
    exp_q.push_back({2'b01, 8'hA0});
    for (int k = 0; k < 7; k++) begin
      @(posedge clk_sys);
      to_mid();
      chk($sformatf("rr_grant_%0d", k), 32'(grant), 32'(exp_g[k]));
    end
    to_edge();
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    to_mid();
    chk("rr_release", 32'(grant), 32'd0);

    // Backpressure on requester 1 for 5 cycles
    to_edge();
    drive(2'b10, 8'h5A, 8'h00, 2'b10);
    tx_ready = 1'b0;
    exp_q.push_back({2'b10, 8'h5A});
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_sys);
      to_mid();
      chk("bp_grant", 32'(grant), 32'b10);
      chk("bp_tx_data", 32'(tx_data), 32'h5A);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    to_edge();
    tx_ready = 1'b1;
    to_mid();
    chk("bp_ready_rise", 32'(req_ready), 32'b10);
    to_edge();
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    to_mid();
    chk("bp_release", 32'(grant), 32'd0);

    // Timeout: owner 0 sends one non-last byte then stalls
    to_edge();
    drive(2'b01, 8'h00, 8'h77, 2'b00);
    exp_q.push_back({2'b01, 8'h77});
    @(posedge clk_sys);
    to_mid();
    chk("to_grant", 32'(grant), 32'b01);
    to_edge();
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_sys);
      to_mid();
      chk($sformatf("to_wait_evt_%0d", k), 32'(timeout_evt), 32'd0);
      chk($sformatf("to_wait_grant_%0d", k), 32'(grant), 32'b01);
    end
    @(posedge clk_sys);
    to_mid();
    chk("to_pulse", 32'(timeout_evt), 32'd1);
    chk("to_grant_cleared", 32'(grant), 32'd0);
    @(posedge clk_sys);
    to_mid();
    chk("to_pulse_width", 32'(timeout_evt), 32'd0);

    // After timeout pointer is 1: requester 1 wins over 0
    to_edge();
    drive(2'b11, 8'h99, 8'h78, 2'b10);
    exp_q.push_back({2'b10, 8'h99});
    exp_q.push_back({2'b01, 8'h78});
    @(posedge clk_sys);
    to_mid();
    chk("to_ptr_next", 32'(grant), 32'b10);
    to_edge();
    drive(2'b01, 8'h00, 8'h78, 2'b00);
    to_mid();
    chk("no_rearb_on_end", 32'(grant), 32'd0);
    @(posedge clk_sys);
    to_mid();
    chk("to2_grant", 32'(grant), 32'b01);
    to_edge();
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk_sys);
      to_mid();
      chk("to2_wait_evt", 32'(timeout_evt), 32'd0);
    end
    // Valid returns on the fourth idle cycle and must beat the timeout
    to_edge();
    drive(2'b01, 8'h00, 8'h79, 2'b00);
    exp_q.push_back({2'b01, 8'h79});
    to_mid();
    chk("to2_idle4_grant", 32'(grant), 32'b01);
    to_edge();
    drive(2'b01, 8'h00, 8'h7A, 2'b01);
    exp_q.push_back({2'b01, 8'h7A});
    to_mid();
    chk("to2_no_pulse", 32'(timeout_evt), 32'd0);
    chk("to2_still_owned", 32'(grant), 32'b01);
    to_edge();
    drive(2'b00, 8'h00, 8'h00, 2'b00);
    to_mid();
    chk("to2_release", 32'(grant), 32'd0);
    chk("to2_release_evt", 32'(timeout_evt), 32'd0);

    // Reset in the middle of requester 1's second byte
    to_edge();
    drive(2'b10, 8'hC1, 8'h00, 2'b00);
    exp_q.push_back({2'b10, 8'hC1});
    @(posedge clk_sys);
    to_mid();
    chk("rst_pkt_grant", 32'(grant), 32'b10);
    to_edge();
    drive(2'b10, 8'hC2, 8'h00, 2'b00);
    #2;
    rst_sys_n = 1'b0;
    #1;
    chk("rst_async_grant", 32'(grant), 32'd0);
    chk("rst_async_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_async_req_ready", 32'(req_ready), 32'd0);
    chk("rst_async_tx_data", 32'(tx_data), 32'd0);
    drive(2'b11, 8'hC2, 8'hD0, 2'b01);
    exp_q.push_back({2'b01, 8'hD0});
    @(posedge clk_sys);
    to_mid();
    chk("rst_held_grant", 32'(grant), 32'd0);
    #1 rst_sys_n = 1'b1;
    @(posedge clk_sys);
    to_mid();
    chk("rst_restart_ptr0", 32'(grant), 32'b01);
    @(posedge clk_sys);
    to_mid();
    chk("rst_pkt_end_idle", 32'(grant), 32'd0);
    #1 drive(2'b00, 8'h00, 8'h00, 2'b00);
    repeat (3) to_mid();
    chk("final_idle", 32'(grant), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2 (legal 2..4): number of requesters sharing the UART transmitter.
REQ-002 SHALL have parameter HOLD_TIMEOUT, default 1024 (0..65535): idle cycles tolerated mid-packet before the grant is revoked; 0 disables the timeout.
REQ-003 SHALL have port clk_sys, input, 1: system clock, all logic on its rising edge; one clock domain only.
REQ-004 SHALL have port rst_sys_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ: per-requester byte valid.
REQ-006 SHALL have port req_data, input, 8*NUM_REQ: per-requester byte, requester i in bits [8i+7:8i].
REQ-007 SHALL have port req_last, input, NUM_REQ: marks the final byte of a requester's packet.
REQ-008 SHALL have port req_ready, output, NUM_REQ: per-requester byte accepted.
REQ-009 SHALL have port tx_data, output, 8: byte to the UART transmitter.
REQ-010 SHALL have port tx_valid, output, 1: byte valid to the UART transmitter.
REQ-011 SHALL have port tx_ready, input, 1: UART transmitter accepts the byte.
REQ-012 SHALL have port grant, output, NUM_REQ: one-hot current owner, all-zero when unowned.
REQ-013 SHALL have port timeout_evt, output, 1: one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no owner) and LOCK (one owner).
REQ-015 In IDLE with any req_valid high, SHALL select the first valid requester scanning ptr, ptr+1, ... mod NUM_REQ, register it into grant and enter LOCK on the next edge. Valid-to-grant latency is 1 cycle.
REQ-016 In IDLE with no req_valid, SHALL remain in IDLE with grant = 0.
REQ-017 In LOCK, SHALL combinationally route the owner g: tx_data = req_data[g], tx_valid = req_valid[g], req_ready[g] = tx_ready; every other req_ready SHALL be 0.
REQ-018 In IDLE, tx_valid and all req_ready SHALL be 0. tx_data SHALL be 0.
REQ-019 A beat transfers when tx_valid and tx_ready are both high. When a transferred beat has req_last[g]=1, the FSM SHALL go to IDLE, set grant to 0 and set ptr to (g+1) mod NUM_REQ on the same edge.
REQ-020 SHALL NOT re-arbitrate in the cycle a packet ends. There is a minimum of one IDLE cycle between packets.
REQ-021 Requests from non-owners SHALL be ignored in LOCK. Their req_ready stays 0 and their data is not consumed.
REQ-022 SHALL hold a 16-bit idle counter. It clears on entry to LOCK and in any LOCK cycle with req_valid[g]=1, and increments in LOCK cycles with req_valid[g]=0. It saturates and never wraps.
REQ-023 When HOLD_TIMEOUT ≠ 0 and the counter reaches HOLD_TIMEOUT in LOCK, SHALL go to IDLE. On that edge it SHALL clear grant, set ptr to (g+1) mod NUM_REQ and pulse timeout_evt for exactly one cycle.
REQ-024 If req_valid[g] returns in the same cycle the counter would reach HOLD_TIMEOUT, the valid SHALL win: the counter clears and there is no timeout.
REQ-025 A last-beat transfer and a timeout SHALL never coincide, because a transfer implies valid and valid clears the counter.
REQ-026 With HOLD_TIMEOUT = 0, the grant SHALL be held indefinitely until req_last transfers.
REQ-027 The owner SHALL keep tx_data stable while tx_valid is high and tx_ready is low. The arbiter SHALL not alter the routing in that condition.
REQ-028 grant SHALL always be one-hot or zero, and its ptr value SHALL always be less than NUM_REQ.

Reset
REQ-029 On rst_sys_n low, asynchronously: state IDLE, grant = 0, ptr = 0, counter = 0, timeout_evt = 0. As a result tx_valid = 0, req_ready = 0 and tx_data = 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet with no further transfer. After release, arbitration SHALL restart from ptr = 0.
REQ-031 After deassertion, the first grant SHALL occur no earlier than the first rising edge with req_valid sampled high.

Verification
REQ-032 Single packet: req_valid[0]=1, 3 bytes 0x41,0x42,0x43 with last on 0x43, tx_ready=1 -> grant=01 one cycle later, 3 consecutive tx transfers, then grant=00 and ptr=1.
REQ-033 Round-robin contention: req_valid=11 continuously, 1-byte packets (last=1) -> grant sequence 01,00,10,00,01,00,10, with both requesters served alternately.
REQ-034 Backpressure: owner 1, tx_ready low for 5 cycles with byte 0x5A -> tx_data held at 0x5A, req_ready[1]=0 for those cycles, exactly one transfer when tx_ready rises.
REQ-035 Timeout: HOLD_TIMEOUT=4, owner 0 sends 1 non-last byte then drops valid -> timeout_evt pulses 4 cycles after the drop, grant=00, ptr=1. The same run with valid returned on idle cycle 4 -> no pulse.
REQ-036 Reset mid-packet: rst_sys_n low during owner 1's second byte -> grant=00, tx_valid=0 immediately. After release with req_valid=11 -> grant=01.
